// File: rtl/msg_writeback_arbiter.sv
// Round-robin arbiter sharing the core writeback port among message-unit result sources.
// Optional starvation override: define XCTCMSG_WB_AGE_EN.

package msg_writeback_arbiter_pkg;

    typedef struct packed {
        logic [31:0] value;
        logic [4:0]  register;
        logic        passthrough;
    } writeback_arbiter_data_t;

    localparam int WB_DATA_W = $bits(writeback_arbiter_data_t);

endpackage

module msg_writeback_arbiter
    import msg_writeback_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int MAX_WAIT = 8,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_acknowledge,
    input  logic [NUM_REQ-1:0][WB_DATA_W-1:0]  req_data,
    output logic                               wb_valid,
    input  logic                               wb_ready,
    output logic [WB_DATA_W-1:0]               wb_data,
    output logic [IDX_W-1:0]                   wb_source
);

    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || MAX_WAIT < 1) begin : g_bad_cfg
        $error("msg_writeback_arbiter: NUM_REQ must be >= 2 and MAX_WAIT >= 1");
    end

    logic                 out_valid;
    logic [IDX_W-1:0]     rr_ptr;
    logic                 cap_en;
    logic                 grant_any;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W:0]       scan_idx;
    logic [NUM_REQ-1:0]   ack_int;

`ifdef XCTCMSG_WB_AGE_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt [NUM_REQ];
    logic             aged_any;
`endif

    assign cap_en   = (!out_valid || wb_ready) && !flush;
    assign wb_valid = out_valid;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Scan starts at rr_ptr; explicit wrap keeps non-power-of-two counts correct.
            scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!grant_any && req_valid[scan_idx[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[IDX_W-1:0];
            end
        end
`ifdef XCTCMSG_WB_AGE_EN
        aged_any = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!aged_any && req_valid[i] && wait_cnt[i] == MAX_WAIT_C) begin
                aged_any  = 1'b1;
                grant_any = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
`endif
    end

    always_comb begin
        ack_int = '0;
        if (cap_en && grant_any) begin
            ack_int[grant_idx] = 1'b1;
        end
    end

    // Reset gates only the outgoing acknowledge so no requester sees a grant during reset.
    assign req_acknowledge = ack_int & {NUM_REQ{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rr_ptr    <= '0;
            wb_data   <= '0;
            wb_source <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (|ack_int) begin
                out_valid <= 1'b1;
                wb_data   <= req_data[grant_idx];
                wb_source <= grant_idx;
                rr_ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end else if (wb_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef XCTCMSG_WB_AGE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (flush || !req_valid[i] || ack_int[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != MAX_WAIT_C) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_chk
        a_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[g] && !req_acknowledge[g] && !flush) |=> req_valid[g]);
        a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[g] && !req_acknowledge[g] && !flush) |=> $stable(req_data[g]));
    end

    a_wb_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_valid && !wb_ready) |=> $stable(wb_data) && $stable(wb_source));

endmodule

// File: tb/tb_msg_writeback_arbiter.sv
// Directed self-checking bench for msg_writeback_arbiter (default build, NUM_REQ=3).

module tb_msg_writeback_arbiter;
    import msg_writeback_arbiter_pkg::*;

    logic                          clk;
    logic                          rst_n;
    logic                          flush;
    logic [2:0]                    req_valid;
    logic [2:0]                    req_acknowledge;
    logic [2:0][WB_DATA_W-1:0]     req_data;
    logic                          wb_valid;
    logic                          wb_ready;
    logic [WB_DATA_W-1:0]          wb_data;
    logic [1:0]                    wb_source;

    int total = 0;
    int bad   = 0;

    msg_writeback_arbiter #(.NUM_REQ(3), .MAX_WAIT(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .req_valid       (req_valid),
        .req_acknowledge (req_acknowledge),
        .req_data        (req_data),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_data         (wb_data),
        .wb_source       (wb_source)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WB_DATA_W-1:0] mk(input int i, input int seq);
        logic [31:0] v;
        logic [31:0] r;
        v = 32'h1000_0000 + 32'(i * 256 + seq);
        r = 32'(i + 3);
        return {v, r[4:0], r[0]};
    endfunction

    int rr_order [5] = '{0, 1, 2, 0, 1};

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        wb_ready  = 1'b0;
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) req_data[i] = mk(i, 0);

        // Reset state, with requests pending to show the acknowledge is gated.
        repeat (2) @(negedge clk);
        #1;
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_ack", 64'(req_acknowledge), 64'd0);
        check("rst_wb_source", 64'(wb_source), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);

        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 3'b001;
        wb_ready  = 1'b1;

        // Single requester: one result per cycle.
        for (int k = 0; k < 4; k++) begin
            req_data[0] = mk(0, k + 1);
            #1;
            check("single_ack", 64'(req_acknowledge), 64'b001);
            @(posedge clk); #1;
            check("single_wb_valid", 64'(wb_valid), 64'd1);
            check("single_wb_source", 64'(wb_source), 64'd0);
            check("single_wb_data", 64'(wb_data), 64'(mk(0, k + 1)));
            @(negedge clk);
        end

        // Reset mid-operation: rr_ptr is 1 here, so requester 1 is acknowledged first.
        req_valid   = 3'b111;
        req_data[0] = mk(0, 0);
        #1;
        check("pre_rst_ack", 64'(req_acknowledge), 64'b010);
        check("pre_rst_wb_valid", 64'(wb_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_wb_valid", 64'(wb_valid), 64'd0);
        check("async_rst_ack", 64'(req_acknowledge), 64'd0);
        check("async_rst_wb_source", 64'(wb_source), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin wrap from rr_ptr=0.
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_ack", 64'(req_acknowledge), 64'(3'b001 << rr_order[k]));
            @(posedge clk); #1;
            check("rr_wb_source", 64'(wb_source), 64'(rr_order[k]));
            check("rr_wb_data", 64'(wb_data), 64'(mk(rr_order[k], 0)));
            @(negedge clk);
        end

        req_valid = 3'b101;
        #1;
        check("rr_tail_ack2", 64'(req_acknowledge), 64'b100);
        @(posedge clk); #1;
        check("rr_tail_src2", 64'(wb_source), 64'd2);
        @(negedge clk);
        req_valid = 3'b001;
        #1;
        check("rr_tail_ack0", 64'(req_acknowledge), 64'b001);
        @(posedge clk); #1;
        check("rr_tail_src0", 64'(wb_source), 64'd0);
        @(negedge clk);

        // Backpressure: 4 stalled cycles, then simultaneous drain and capture.
        req_valid = 3'b110;
        wb_ready  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_ack", 64'(req_acknowledge), 64'd0);
            @(posedge clk); #1;
            check("bp_wb_valid", 64'(wb_valid), 64'd1);
            check("bp_wb_source", 64'(wb_source), 64'd0);
            check("bp_wb_data", 64'(wb_data), 64'(mk(0, 0)));
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1;
        check("bp_release_ack", 64'(req_acknowledge), 64'b010);
        @(posedge clk); #1;
        check("bp_release_valid", 64'(wb_valid), 64'd1);
        check("bp_release_src", 64'(wb_source), 64'd1);
        check("bp_release_data", 64'(wb_data), 64'(mk(1, 0)));
        @(negedge clk);
        req_valid = 3'b100;
        #1;
        check("bp_next_ack", 64'(req_acknowledge), 64'b100);
        @(posedge clk); #1;
        check("bp_next_src", 64'(wb_source), 64'd2);
        @(negedge clk);

        // Flush discards the held result and captures nothing; rr_ptr stays at 0.
        req_valid = 3'b010;
        flush     = 1'b1;
        #1;
        check("flush_ack", 64'(req_acknowledge), 64'd0);
        @(posedge clk); #1;
        check("flush_wb_valid", 64'(wb_valid), 64'd0);
        check("flush_wb_source", 64'(wb_source), 64'd2);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("post_flush_ack", 64'(req_acknowledge), 64'b010);
        @(posedge clk); #1;
        check("post_flush_valid", 64'(wb_valid), 64'd1);
        check("post_flush_src", 64'(wb_source), 64'd1);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        check("idle_ack", 64'(req_acknowledge), 64'd0);
        @(posedge clk); #1;
        check("drain_wb_valid", 64'(wb_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
